// File: rtl/adder_sched.sv
// -----------------------------------------------------------------------------
// adder_sched
// Arbitrates NREQ requesters for one shared up-counting adder. The winner's
// operation is latched at the grant edge: either clear the adder, or increment
// it N times. The scheduler waits one cycle for the registered adder output to
// settle, then returns the adder value with a one-cycle done pulse.
//
// Ports
//   aclk       : clock, rising edge
//   srst       : synchronous active-high reset
//   req        : per-requester request level                [NREQ]
//   req_clr    : per-requester op select, 1=clear 0=inc       [NREQ]
//   req_cnt    : per-requester increment count, CNTW each     [NREQ*CNTW]
//   gnt        : one-hot grant, held for the whole operation  [NREQ]
//   done       : one-cycle completion pulse
//   rsp_data   : adder value captured for the completed op    [WIDTH]
//   busy       : high whenever the FSM is not idle
//   adder_clr  : clear strobe to the shared adder
//   adder_inc  : increment strobe to the shared adder
//   adder_out  : registered output of the shared adder        [WIDTH]
//
// Build option
//   ADDER_SCHED_FIXED_PRIO_EN : when defined, lowest asserted index always
//                               wins; otherwise round-robin arbitration.
// -----------------------------------------------------------------------------
module adder_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic                 aclk,
    input  logic                 srst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_clr,
    input  logic [NREQ*CNTW-1:0] req_cnt,
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic [WIDTH-1:0]     rsp_data,
    output logic                 busy,
    output logic                 adder_clr,
    output logic                 adder_inc,
    input  logic [WIDTH-1:0]     adder_out
);

    localparam int PTRW = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q,   gnt_d;
    logic              clr_q,   clr_d;
    logic [CNTW-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]  rsp_q,   rsp_d;

    logic              win_valid;
    logic [PTRW-1:0]   win_idx;
    logic              win_clr;
    logic [CNTW-1:0]   win_cnt;

    // ---------------------------------------------------------------- arbiter
`ifdef ADDER_SCHED_FIXED_PRIO_EN
    // Scan from the highest index down so the lowest asserted index is the
    // last assignment and therefore wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                win_valid = 1'b1;
                win_idx   = PTRW'(k);
            end
        end
    end
`else
    logic [PTRW-1:0] ptr_q;
    int              cand;

    // Candidates are visited from ptr+NREQ (the last winner itself) down to
    // ptr+1, so the one nearest after the last winner is assigned last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = PTRW'(cand);
            end
        end
    end

    // Pointer starts at NREQ-1 so requester 0 is searched first after reset.
    always_ff @(posedge aclk) begin
        if (srst) begin
            ptr_q <= PTRW'(NREQ - 1);
        end else if (state_q == ST_IDLE && win_valid) begin
            ptr_q <= win_idx;
        end
    end
`endif

    assign win_clr = req_clr[win_idx];
    assign win_cnt = req_cnt[win_idx*CNTW +: CNTW];

    // -------------------------------------------------------------------- FSM
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        clr_d     = clr_q;
        cnt_d     = cnt_q;
        rsp_d     = rsp_q;
        adder_clr = 1'b0;
        adder_inc = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    gnt_d = NREQ'(1) << win_idx;
                    clr_d = win_clr;
                    cnt_d = win_cnt;
                    // A zero-count increment has nothing to drive.
                    if (!win_clr && win_cnt == '0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (clr_q) begin
                    adder_clr = 1'b1;
                    state_d   = ST_WAIT;
                end else begin
                    adder_inc = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                    if (cnt_q == CNTW'(1)) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Adder has taken its last strobe by now and stays still
                // through DONE, so capturing here presents it during done.
                rsp_d   = adder_out;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            clr_q   <= 1'b0;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);
    assign rsp_data = rsp_q;

endmodule
